// File: rtl/mems_rom_arbiter.sv
// mems_rom_arbiter: shares one single-port waveform ROM among N_REQ channels with round-robin grants
// Ports: clk, rst_n (async active-low); req/req_addr per channel in; gnt/rd_valid one-hot pulses out;
// rd_data registered ROM byte; rom_addr registered ROM address; rom_dout ROM data in; busy = read in flight.
// Define MEMS_ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr held at 0).
module mems_rom_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_dout,
    output logic                    busy
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic [IW-1:0] ptr, owner, win;
    logic [2:0] cnt;
    logic hit;
    logic [ADDR_W-1:0] sel_addr;
    int base, j;
    // search starts at ptr and wraps; first set request wins
    always_comb begin
`ifdef MEMS_ROM_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = int'(ptr);
`endif
        win = '0;
        hit = 1'b0;
        j = 0;
        sel_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = base + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!hit && req[IW'(j)]) begin
                hit = 1'b1;
                win = IW'(j);
            end
        end
        for (int k = 0; k < N_REQ; k++)
            if (win == IW'(k)) sel_addr = req_addr[k*ADDR_W +: ADDR_W];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            owner    <= '0;
        end else begin
            gnt      <= '0;
            rd_valid <= '0;
            if (state == IDLE) begin
                if (hit) begin
                    rom_addr <= sel_addr;
                    gnt      <= N_REQ'(1) << win;
                    owner    <= win;
`ifdef MEMS_ROM_ARB_FIXED_PRIO_EN
                    ptr      <= '0;
`else
                    ptr      <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
`endif
                    cnt      <= '0;
                    busy     <= 1'b1;
                    state    <= WAIT;
                end
            end else begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'(ROM_LAT-1)) begin
                    rd_data  <= rom_dout;
                    rd_valid <= N_REQ'(1) << owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_mems_rom_arbiter.sv
// tb_mems_rom_arbiter: directed checks of grant order, data return, busy and reset behaviour
module tb_mems_rom_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] req = '0;
    logic [41:0] req_addr = '0;
    logic [2:0] gnt, rd_valid;
    logic [7:0] rd_data, rom_dout = '0;
    logic [13:0] rom_addr;
    logic busy;
    int errors = 0, checks = 0;

    mems_rom_arbiter dut (.clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy));

    always #5 clk = ~clk;
    // ROM: registered output one cycle after rom_addr, so data is ready at the second edge after grant
    always @(posedge clk) rom_dout <= rom_addr[7:0] ^ 8'h86;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 3'b111;
        req_addr = {14'h2222, 14'h1111, 14'h0010};
        tick();
        tick();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
        checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rd_valid got %b exp 000", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (rom_addr !== 14'h0000) begin errors++; $display("FAIL reset_rom_addr got %h exp 0000", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL release_gnt got %b exp 001", gnt); end
        checks++; if (rom_addr !== 14'h0010) begin errors++; $display("FAIL release_rom_addr got %h exp 0010", rom_addr); end
        req = 3'b000;
        tick();
        tick();
        checks++; if (rd_valid !== 3'b001 || rd_data !== 8'h96) begin errors++; $display("FAIL release_data got %b/%h exp 001/96", rd_valid, rd_data); end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        req = 3'b010;
        req_addr[14 +: 14] = 14'h0123;
        tick();
        req = 3'b000;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", gnt); end
        checks++; if (rom_addr !== 14'h0123) begin errors++; $display("FAIL single_rom_addr got %h exp 0123", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", busy); end
        tick();
        checks++; if (gnt !== 3'b000 || rd_valid !== 3'b000) begin errors++; $display("FAIL single_mid got gnt=%b rv=%b exp 000/000", gnt, rd_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b exp 1", busy); end
        tick();
        checks++; if (rd_valid !== 3'b010) begin errors++; $display("FAIL single_rd_valid got %b exp 010", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_rd_data got %h exp a5", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy3 got %b exp 0", busy); end
        tick();
        checks++; if (rd_valid !== 3'b000 || rd_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %b/%h exp 000/a5", rd_valid, rd_data); end
    endtask

    task automatic test_round_robin();
        logic [2:0] oh;
        logic [13:0] a;
        do_reset();
        req_addr = {14'h2222, 14'h1111, 14'h0010};
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
`ifdef MEMS_ROM_ARB_FIXED_PRIO_EN
            oh = 3'b001;
`else
            oh = 3'b001 << (i % 3);
`endif
            a = (oh == 3'b001) ? 14'h0010 : (oh == 3'b010) ? 14'h1111 : 14'h2222;
            tick();
            checks++; if (gnt !== oh) begin errors++; $display("FAIL rr_gnt slot %0d got %b exp %b", i, gnt, oh); end
            tick();
            checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_gap slot %0d got %b exp 000", i, gnt); end
            tick();
            checks++; if (rd_valid !== oh || rd_data !== (a[7:0] ^ 8'h86)) begin
                errors++; $display("FAIL rr_data slot %0d got %b/%h exp %b/%h", i, rd_valid, rd_data, oh, a[7:0] ^ 8'h86); end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_rerequest();
        do_reset();
        req = 3'b001;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rereq_first got %b exp 001", gnt); end
        req = 3'b101;
        tick();
        tick();
        tick();
`ifdef MEMS_ROM_ARB_FIXED_PRIO_EN
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rereq_second got %b exp 001", gnt); end
`else
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL rereq_second got %b exp 100", gnt); end
`endif
        tick();
        tick();
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rereq_third got %b exp 001", gnt); end
        req = 3'b000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req = 3'b010;
        req_addr[14 +: 14] = 14'h0077;
        tick();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL mid_gnt got %b exp 010", gnt); end
        req = 3'b000;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rom_addr !== 14'h0) begin errors++; $display("FAIL mid_async got busy=%b addr=%h exp 0/0000", busy, rom_addr); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rd_valid !== 3'b000 || rd_data !== 8'h00) begin
                errors++; $display("FAIL mid_after cycle %0d got %b/%h exp 000/00", i, rd_valid, rd_data); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_rerequest();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mems_rom_arbiter.md
# mems_rom_arbiter

Round-robin arbiter that shares the single-port waveform ROM (8-bit data, 14-bit address, registered output) among the three MEMS DAC frame channels (f1/f2/f3). Each channel requests a ROM byte with a request/grant handshake and gets a per-channel data-valid strobe when the byte returns. The block replaces the hard-wired F1→F2→F3 read rotation: idle channels consume no ROM slots, and the ROM read latency is a parameter.

## Interface
- N_REQ, 3, number of requesting channels (2..8)
- ADDR_W, 14, ROM address width
- DATA_W, 8, ROM data width
- ROM_LAT, 2, cycles from ROM address register update to valid rom_dout (1..7)

- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low; release must be synchronous to clk upstream
- req  in  N_REQ  per-channel read request, level
- req_addr  in  N_REQ*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot, 1-cycle pulse; the address has been captured
- rd_valid  out  N_REQ  one-hot, 1-cycle pulse; rd_data is valid for that channel
- rd_data  out  DATA_W  registered ROM byte; held until the next capture
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_dout  in  DATA_W  ROM read data
- busy  out  1  high while a read is in flight (state WAIT)

## Operation
- States: IDLE, WAIT. Reset state is IDLE.
- Reset values: gnt=0, rd_valid=0, rd_data=0, rom_addr=0, busy=0, rr pointer ptr=0, cnt=0, owner=0.
- IDLE, any req bit set:
  - Winner is the first set bit searching ptr, ptr+1, … modulo N_REQ.
  - On that edge: rom_addr←req_addr[winner], gnt←onehot(winner), owner←winner, ptr←(winner+1) mod N_REQ, cnt←0, state←WAIT.
- IDLE, no req: all pulses 0; rom_addr holds.
- WAIT: cnt increments each edge. At the edge where cnt==ROM_LAT-1:
  - rd_data←rom_dout, rd_valid←onehot(owner), state←IDLE.
  - req is ignored throughout WAIT.
- Requester rules:
  - Hold req and req_addr stable until gnt is seen.
  - Deassert req in the gnt cycle unless another read is wanted; a req still high in the next IDLE cycle is treated as a new request.
  - A channel may re-request immediately; it competes fairly through ptr.
- gnt and rd_valid each deassert after exactly one cycle.
- Reset mid-read: everything clears immediately. The pending read is dropped and no rd_valid is issued after reset release.

## Timing
- Grant latency: req high in IDLE at edge E → gnt high in cycle E..E+1 and rom_addr updated at E.
- Data latency: rd_valid high ROM_LAT cycles after gnt (edge E+ROM_LAT).
- Throughput: one read per ROM_LAT+1 cycles when requests are continuous (3 cycles at default).
- Worst-case wait for a continuously requesting channel: (N_REQ-1)·(ROM_LAT+1) cycles before its grant.
- busy is high from edge E to edge E+ROM_LAT, inclusive of the rd_valid cycle boundary: busy=0 in the rd_valid cycle.
- cnt width: 3 bits, no wrap inside legal ROM_LAT.

## Configuration
- MEMS_ROM_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest-index set req always wins and ptr is unused (held at 0).
  - Lets f1 (carrying soft-reset/Vref frames) never be starved by f2/f3.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: rst_n=0 with req=3'b111 → all outputs 0 and no gnt. Release; the first edge gives gnt=3'b001 and rom_addr=req_addr[0].
- Single read: req=3'b010, addr1=14'h0123, ROM model returns 8'hA5 → gnt=3'b010 at cycle 1, rd_valid=3'b010 with rd_data=8'hA5 at cycle 3, busy high for cycles 1–2.
- Round-robin: req held at 3'b111 → grant order 0,1,2,0,… with gnts every 3 cycles, each rd_valid matching that channel's ROM byte.
- Re-request: ch0 keeps req high after gnt while ch2 requests → ch2 is granted before ch0's second grant.
- Reset mid-read: assert rst_n=0 one cycle after gnt → no rd_valid after release and rd_data=0.
- With MEMS_ROM_ARB_FIXED_PRIO_EN: req=3'b111 held → ch0 is granted every slot and ch1/ch2 are never granted while ch0 requests.
